seg14_text_buffer: RTL and testbench

- Upstream feeder for the 12-digit 14-segment scan multiplexer.
- Stores a message of up to DEPTH raw 14-bit segment patterns, loaded through a valid/ready write port.
- Scrolls the message circularly across a DIGITS-wide window at a prescaled rate.
- The scanner presents its digit index; this block returns the registered segment pattern for that digit position.

---
 rtl/seg14_text_buffer_if.sv | 12 +
 rtl/seg14_text_buffer.sv | 158 +++++++++++++++
 tb/tb_seg14_text_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg14_text_buffer_if.sv
// Write port bundle for seg14_text_buffer: valid/ready character load
// with an end-of-message marker. The feeder drives the master side and
// the buffer sits on the slave side.
interface seg14_text_buffer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [13:0] wr_data;
  logic        wr_last;

  modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);
endinterface

// File: rtl/seg14_text_buffer.sv
// seg14_text_buffer: message store and circular scroller feeding the
// 12-digit 14-segment scan multiplexer. Characters are loaded as raw
// segment patterns over the write interface, the committed message is
// scrolled across a DIGITS-wide window at a prescaled rate, and the
// pattern for the scanner's current digit is returned one cycle later.
// Optional build macro: SEG14_SCROLL_GAP_EN inserts one blank position
// between repeats of a scrolling message.
module seg14_text_buffer #(
  parameter int unsigned DIGITS     = 12,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned SCROLL_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  seg14_text_buffer_if.slave       wr,
  input  logic                     clear_i,
  input  logic                     scroll_en_i,
  input  logic [3:0]               digit_idx_i,
  output logic [13:0]              seg_out_o,
  output logic [5:0]               msg_len_o,
  output logic                     showing_o
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PSW = $clog2(SCROLL_DIV + 1);

  localparam logic [5:0]     DEPTH_L  = 6'(DEPTH);
  localparam logic [5:0]     DIGITS_L = 6'(DIGITS);
  localparam logic [PSW-1:0] PS_MAX   = PSW'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHOW
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     ptr_q, ptr_d;
  logic [5:0]     len_q, len_d;
  logic [5:0]     off_q, off_d;
  logic [PSW-1:0] ps_q, ps_d;
  logic [13:0]    seg_q, seg_d;
  logic [13:0]    mem_q [DEPTH];

  logic           xfer;
  logic [6:0]     l_eff;
  logic [5:0]     idx_ext;
  logic [6:0]     sum;
  logic [6:0]     k;

  assign wr.wr_ready = (state_q != SHOW) && (ptr_q < DEPTH_L) && !clear_i;
  assign xfer        = wr.wr_valid && wr.wr_ready;
  assign idx_ext     = {2'b00, digit_idx_i};

`ifdef SEG14_SCROLL_GAP_EN
  assign l_eff = {1'b0, len_q} + 7'd1;
`else
  assign l_eff = {1'b0, len_q};
`endif

  // State, pointer, length, scroll offset and prescaler registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      off_q   <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      off_q   <= off_d;
      ps_q    <= ps_d;
    end
  end

  // Next-state: load handshake, commit, scroll stepping; clear overrides all
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    off_d   = off_q;
    ps_d    = ps_q;
    if (clear_i) begin
      state_d = IDLE;
      ptr_d   = '0;
      len_d   = '0;
      off_d   = '0;
      ps_d    = '0;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (xfer) begin
            ptr_d   = ptr_q + 6'd1;
            state_d = LOAD;
            if (wr.wr_last || (ptr_q == DEPTH_L - 6'd1)) begin
              state_d = SHOW;
              len_d   = ptr_q + 6'd1;
              off_d   = '0;
            end
          end
        end
        SHOW: begin
          if (scroll_en_i) begin
            if (ps_q == PS_MAX) begin
              ps_d = '0;
              if (len_q > DIGITS_L) begin
                off_d = (({1'b0, off_q} + 7'd1) == l_eff) ? '0 : off_q + 6'd1;
              end
            end else begin
              ps_d = ps_q + PSW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Character storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem_q[ptr_q[AW-1:0]] <= wr.wr_data;
    end
  end

  // Window lookup: offset < L and digit < DIGITS <= L, so one subtract wraps.
  // Index == msg_len only arises with the gap and reads as blank.
  always_comb begin
    seg_d = '0;
    sum   = {1'b0, off_q} + {3'b000, digit_idx_i};
    k     = (sum >= l_eff) ? sum - l_eff : sum;
    if ((state_q == SHOW) && (idx_ext < DIGITS_L)) begin
      if (len_q <= DIGITS_L) begin
        if (idx_ext < len_q) begin
          seg_d = mem_q[idx_ext[AW-1:0]];
        end
      end else if (k < {1'b0, len_q}) begin
        seg_d = mem_q[k[AW-1:0]];
      end
    end
  end

  // Registered segment output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg_out_o = seg_q;
  assign msg_len_o = len_q;
  assign showing_o = (state_q == SHOW);

endmodule

// File: tb/tb_seg14_text_buffer.sv
// Self-checking bench for seg14_text_buffer (DIGITS=12, DEPTH=32,
// SCROLL_DIV=4). Lookup expectations come from a behavioural model of
// the message and scroll offset and are queued with the cycle their
// result is due; a negedge monitor pops and compares them.
module tb_seg14_text_buffer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        scroll_en;
  logic [3:0]  digit_idx;
  logic [13:0] seg_out;
  logic [5:0]  msg_len;
  logic        showing;

  seg14_text_buffer_if wr_if ();

  seg14_text_buffer #(
    .DIGITS     (12),
    .DEPTH      (32),
    .SCROLL_DIV (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr          (wr_if.slave),
    .clear_i     (clear),
    .scroll_en_i (scroll_en),
    .digit_idx_i (digit_idx),
    .seg_out_o   (seg_out),
    .msg_len_o   (msg_len),
    .showing_o   (showing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model of the buffer contents
  logic [13:0] m_mem [32];
  int          m_ptr;
  int          m_len;
  int          m_off;
  bit          m_show;

`ifdef SEG14_SCROLL_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  function automatic logic [13:0] model_seg(input int d);
    int l;
    int kk;
    if (!m_show || d >= 12) return 14'h0;
    if (m_len <= 12) return (d < m_len) ? m_mem[d] : 14'h0;
    l  = m_len + GAP;
    kk = (m_off + d) % l;
    if (kk >= m_len) return 14'h0;
    return m_mem[kk];
  endfunction

  function automatic void model_clear();
    m_ptr  = 0;
    m_len  = 0;
    m_off  = 0;
    m_show = 0;
  endfunction

  typedef struct {
    string       tag;
    logic [13:0] exp;
    int unsigned due;
  } sb_t;

  sb_t sb_q[$];

  // Scoreboard monitor: compare lookups on the cycle they become valid
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      sb_t e;
      e = sb_q.pop_front();
      if (e.due == cyc) chk(e.tag, 32'(seg_out), 32'(e.exp));
      else chk({e.tag, "_late"}, e.due, cyc);
    end
  end

  // Phase convention: tasks start and end 1 time unit after a posedge.
  task automatic sweep(input string tag, input int lo, input int hi);
    for (int d = lo; d <= hi; d++) begin
      sb_t e;
      digit_idx = 4'(d);
      e.tag = $sformatf("%s_d%0d", tag, d);
      e.exp = model_seg(d);
      e.due = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk); #1;
    end
  endtask

  task automatic wr1(input logic [13:0] d, input logic last);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = d;
    wr_if.wr_last  = last;
    @(negedge clk);
    chk("wr_ready_accept", 32'(wr_if.wr_ready), 32'd1);
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_last  = 1'b0;
    m_mem[m_ptr] = d;
    m_ptr++;
    if (last || m_ptr == 32) begin
      m_show = 1;
      m_len  = m_ptr;
      m_off  = 0;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_clear();
  endtask

  task automatic scroll_cycles(input int n);
    scroll_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    scroll_en = 1'b0;
  endtask

  task automatic status(input string tag, input int exp_show, input int exp_len, input int exp_rdy);
    @(negedge clk);
    chk({tag, "_showing"}, 32'(showing), 32'(exp_show));
    chk({tag, "_msg_len"}, 32'(msg_len), 32'(exp_len));
    chk({tag, "_wr_ready"}, 32'(wr_if.wr_ready), 32'(exp_rdy));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [13:0] pat;
    int          l;

    rst_n          = 1'b1;
    clear          = 1'b0;
    scroll_en      = 1'b0;
    digit_idx      = '0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    wr_if.wr_last  = 1'b0;
    model_clear();

    // 1: reset then idle
    #1 rst_n = 1'b0;
    #2;
    chk("rst_seg_out", 32'(seg_out), 32'd0);
    chk("rst_msg_len", 32'(msg_len), 32'd0);
    chk("rst_showing", 32'(showing), 32'd0);
    chk("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sweep("idle", 0, 15);
    status("idle", 0, 0, 1);

    // 2: short message
    wr1(14'h3BC0, 1'b0);
    wr1(14'h1B24, 1'b0);
    wr1(14'h2F40, 1'b1);
    status("short", 1, 3, 0);
    chk("short_model_p0", 32'(model_seg(0)), 32'h3BC0);
    sweep("short", 0, 15);

    // 3: scroll wrap, 14 characters, pattern = index+1
    do_clear();
    status("clr3", 0, 0, 1);
    for (int i = 0; i < 14; i++) wr1(14'(i + 1), (i == 13));
    status("scroll", 1, 14, 0);
    sweep("scroll_t0", 0, 11);
    l = 14 + GAP;
    for (int t = 1; t <= l; t++) begin
      // three cycles: prescaler not yet wrapped, offset must hold
      scroll_cycles(3);
      repeat (2) @(posedge clk);
      #1;
      sweep($sformatf("scroll_hold%0d", t), 0, 0);
      scroll_cycles(1);
      m_off = (m_off + 1) % l;
      sweep($sformatf("scroll_t%0d", t), 0, 2);
      if (m_off == 13) begin
        pat = (GAP != 0) ? 14'h0 : 14'h1;
        chk("wrap_model_d1", 32'(model_seg(1)), 32'(pat));
      end
    end
    chk("scroll_back_to_0", 32'(m_off), 32'd0);
    sweep("scroll_final", 0, 11);

    // 4: full buffer
    do_clear();
    for (int i = 0; i < 32; i++) begin
      pat = 14'((i * 37 + 5) & 14'h3FFF);
      wr1(pat, 1'b0);
    end
    status("full", 1, 32, 0);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 14'h3FFF;
    @(negedge clk);
    chk("full_33rd_ready", 32'(wr_if.wr_ready), 32'd0);
    @(posedge clk); #1;
    wr_if.wr_valid = 1'b0;
    status("full_after", 1, 32, 0);
    sweep("full", 0, 11);

    // 5: clear priority in SHOW with a pending tick and a write
    scroll_cycles(3);
    clear          = 1'b1;
    scroll_en      = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 14'h2AAA;
    @(negedge clk);
    chk("clr_show_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    @(posedge clk); #1;
    clear          = 1'b0;
    scroll_en      = 1'b0;
    wr_if.wr_valid = 1'b0;
    model_clear();
    status("clr_show", 0, 0, 1);
    sweep("clr_show", 0, 3);

    // 5b: clear with a write while loading; the write must not land
    wr1(14'h0111, 1'b0);
    wr1(14'h0222, 1'b0);
    clear          = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 14'h1555;
    @(negedge clk);
    chk("clr_load_wr_ready", 32'(wr_if.wr_ready), 32'd0);
    @(posedge clk); #1;
    clear          = 1'b0;
    wr_if.wr_valid = 1'b0;
    model_clear();
    wr1(14'h0333, 1'b1);
    status("clr_load", 1, 1, 0);
    sweep("clr_load", 0, 2);

    // 6: async reset mid-load
    do_clear();
    for (int i = 0; i < 5; i++) wr1(14'(14'h0800 + i), 1'b0);
    status("preload", 0, 0, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_seg_out", 32'(seg_out), 32'd0);
    chk("arst_msg_len", 32'(msg_len), 32'd0);
    chk("arst_showing", 32'(showing), 32'd0);
    chk("arst_wr_ready", 32'(wr_if.wr_ready), 32'd1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_clear();
    wr1(14'h1234, 1'b1);
    status("arst", 1, 1, 0);
    sweep("arst", 0, 2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
